// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM fetch cache.
package rom_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FETCH  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic DTACK_OFF = 1'b1;

endpackage

// File: rtl/rom_fetch_tagram.sv
// Direct-mapped valid/tag/data store: synchronous write, combinational read,
// and a flush that clears every valid bit and overrides a same-cycle write.
module rom_fetch_tagram
  import rom_fetch_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic              flush_all,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      valid <= '0;
    end else if (flush_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/rom_fetch_cache.sv
// 68k ROM request logic with a direct-mapped word cache, write bypass,
// aborted-cycle fills, flush and a fetch timeout with a sticky error flag.
module rom_fetch_cache
  import rom_fetch_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic              cpu_ncs,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ndtack,
  input  logic              flush,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  input  logic              rom_ack,
  output logic              fetch_err,
  output logic              hit,
  output logic [1:0]        dbg_state
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  // SDRAM handshake: rom_req is a single-cycle pulse with rom_addr held until
  // the matching single-cycle rom_ack; pending tracks an unanswered request so
  // a late ack is consumed and never mistaken for a later fetch's data.
  state_t            state, state_nxt;
  logic              ncs_q;
  logic              pending, pending_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              ndtack_nxt, req_nxt, err_nxt, hit_nxt, fill;
  logic [ADDR_W-1:0] addr_nxt;
  logic              fall, lookup_hit;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;

  rom_fetch_tagram #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_tagram (
    .clk_sys   (clk_sys),
    .nRESET    (nRESET),
    .flush_all (flush),
    .wr_en     (fill),
    .wr_idx    (rom_addr[IDX_W-1:0]),
    .wr_tag    (rom_addr[ADDR_W-1:IDX_W]),
    .wr_data   (rom_dout),
    .rd_idx    (cpu_addr[IDX_W-1:0]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data)
  );

  assign fall       = ncs_q & ~cpu_ncs;
  // A flush in the lookup cycle must already count, so mask the valid bit here.
  assign lookup_hit = rd_valid & ~flush & (rd_tag == cpu_addr[ADDR_W-1:IDX_W]);
  assign dbg_state  = state;

  always_comb begin
    state_nxt   = state;
    din_nxt     = cpu_din;
    ndtack_nxt  = cpu_ndtack;
    req_nxt     = 1'b0;
    addr_nxt    = rom_addr;
    err_nxt     = fetch_err;
    hit_nxt     = 1'b0;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    fill        = 1'b0;

    if (pending && rom_ack && state != FETCH) begin
      pending_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (fall) begin
          if (!cpu_rw) begin
            ndtack_nxt = 1'b0;
            state_nxt  = HOLD;
          end else begin
            state_nxt = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (cpu_ncs) begin
          state_nxt = IDLE;
        end else if (lookup_hit) begin
          din_nxt    = rd_data;
          ndtack_nxt = 1'b0;
          hit_nxt    = 1'b1;
          state_nxt  = HOLD;
        end else if (!pending) begin
          req_nxt     = 1'b1;
          addr_nxt    = cpu_addr;
          cnt_nxt     = '0;
          pending_nxt = 1'b1;
          state_nxt   = FETCH;
        end
      end
      FETCH: begin
        if (rom_ack) begin
          din_nxt     = rom_dout;
          fill        = 1'b1;
          pending_nxt = 1'b0;
          if (!cpu_ncs) begin
            ndtack_nxt = 1'b0;
            state_nxt  = HOLD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          din_nxt    = '1;
          err_nxt    = 1'b1;
          ndtack_nxt = 1'b0;
          state_nxt  = HOLD;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      HOLD: begin
        if (cpu_ncs) begin
          ndtack_nxt = DTACK_OFF;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state      <= IDLE;
      ncs_q      <= 1'b1;
      pending    <= 1'b0;
      cnt        <= '0;
      cpu_din    <= '0;
      cpu_ndtack <= DTACK_OFF;
      rom_req    <= 1'b0;
      rom_addr   <= '0;
      fetch_err  <= 1'b0;
      hit        <= 1'b0;
    end else begin
      state      <= state_nxt;
      ncs_q      <= cpu_ncs;
      pending    <= pending_nxt;
      cnt        <= cnt_nxt;
      cpu_din    <= din_nxt;
      cpu_ndtack <= ndtack_nxt;
      rom_req    <= req_nxt;
      rom_addr   <= addr_nxt;
      fetch_err  <= err_nxt;
      hit        <= hit_nxt;
    end
  end

endmodule
